ifq_ctrl: RTL and testbench
===========================

// Module: ifq_ctrl
// PURPOSE
//   Instruction fetch queue and fetch sequencer feeding dispatch.
//   - Owns the fetch PC; issues one-outstanding word requests to the I-cache.
//   - Buffers returned words with their PC+4 in a FIFO; dispatch pops them.
//   - Redirects the PC and flushes the FIFO on a dispatch jump/branch.
// PARAMETERS
//   DEPTH     16        FIFO entries; power of two, >= 2
//   PTR_W     4         log2(DEPTH)
//   RESET_PC  32'h0     first fetch address after reset
// PORTS
//   clk                      in   1   single clock, rising edge
//   rst                      in   1   async reset, active-low (asserted at 0)
//   icache_req               out  1   fetch request; level, held until ack
//   icache_addr              out  32  word address; stable while req high
//   icache_ack               in   1   one-cycle pulse, icache_data valid
//   icache_data              in   32  fetched instruction
//   ifq_rd_en                in   1   dispatch pop of head entry
//   ifq_inst                 out  32  head instruction
//   ifq_pc_out               out  32  head PC+4
//   ifq_empty                out  1   FIFO holds no entry
//   ifq_jump_branch_address  in   32  redirect target, word aligned
//   ifq_jump_branch_valid    in   1   redirect + flush, one-cycle pulse
// BEHAVIOUR
//   Reset: icache_req=0, icache_addr=RESET_PC, ifq_inst=0, ifq_pc_out=0,
//     ifq_empty=1, pointers/count=0, state IDLE.
//   FSM (fetch side):
//     IDLE    -> REQ when count < DEPTH; else stay. req=0.
//     REQ     req=1, addr=pc. On ack: push {pc+4,data}, pc+=4;
//             stay REQ if count after push < DEPTH, else IDLE (back-to-back
//             fetch, no bubble). On flush without ack -> DISCARD.
//     DISCARD req=1, addr=old pc (handshake not broken). On ack: drop data,
//             -> REQ with pc=latched target. Second flush: update target only.
//   Flush (ifq_jump_branch_valid=1), effective next edge:
//     - rd/wr pointers and count cleared, ifq_empty=1.
//     - pc <= target; ack in flush cycle is dropped (no push).
//     - From REQ or DISCARD: -> DISCARD if ack absent, else -> REQ with new pc.
//     - From IDLE: -> REQ, addr=target.
//     - Flush wins over a same-cycle ifq_rd_en (pop ignored).
//   FIFO: first-word fall-through, ifq_inst/ifq_pc_out show head, ifq_empty
//     is registered. Push at edge N -> ifq_empty=0 at N+1.
//     - rd_en while empty: ignored, no underflow.
//     - Push and pop same cycle: count unchanged, both pointers advance.
//     - Never full-overflow: request only issued when a slot is free.
//     - Pointers PTR_W wide, wrap modulo DEPTH; count PTR_W+1 wide.
//   Outputs when empty hold last head value (don't-care for dispatch).
//   pc arithmetic 32-bit, wraps 0xFFFF_FFFC -> 0x0 silently.
// CONFIGURATION
//   IFQ_STATS_EN defined: extra outputs stat_fetch_cnt[15:0] (+1 per pushed
//     word) and stat_flush_cnt[15:0] (+1 per flush pulse); both saturate
//     at 16'hFFFF; reset to 0. Discarded acks not counted.
//   IFQ_STATS_EN undefined: ports and counters absent; behaviour identical.
// TESTING
//   1 Release rst, ack every cycle data 0x1000+i, no pops -> addr 0,4,..,0x3C;
//     16 pushes, req drops after 16th ack; head inst 0x1000, pc_out 0x4.
//   2 From full, rd_en 16 cycles -> inst 0x1000..0x100F in order, pc_out
//     4..0x40; req reasserts the cycle after first pop, addr 0x40; empty=1.
//   3 Req at 0x40 pending, flush target 0x200, ack 3 cycles later -> that
//     word dropped, next addr 0x200, first entry pc_out 0x204, empty till then.
//   4 Non-empty FIFO, rd_en and flush (target 0x80) same cycle -> FIFO empty,
//     no pop effect, next fetch addr 0x80.
//   5 Steady push+pop 40 cycles (2x DEPTH wrap) -> count constant, data in
//     order, no lost/duplicated entries.
//   6 With IFQ_STATS_EN, run test 3 -> stat_flush_cnt=1, fetch count excludes
//     dropped word; force 70000 pushes -> stat_fetch_cnt=16'hFFFF.

Source files
------------

// File: rtl/ifq_ctrl.sv
// ifq_ctrl: fetch sequencer and instruction FIFO between I-cache and dispatch.
// Optional IFQ_STATS_EN adds saturating fetch/flush counters.
module ifq_ctrl #(
  parameter int          DEPTH    = 16,
  parameter int          PTR_W    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ack,
  input  logic [31:0] icache_data,
  input  logic        ifq_rd_en,
  output logic [31:0] ifq_inst,
  output logic [31:0] ifq_pc_out,
  output logic        ifq_empty,
  input  logic [31:0] ifq_jump_branch_address,
  input  logic        ifq_jump_branch_valid
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0] stat_fetch_cnt,
  output logic [15:0] stat_flush_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  state_t state, state_n;
  logic [31:0] pc, pc_n, tgt, tgt_n;
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0] count, count_n;
  logic flush, push, pop;
  assign flush = ifq_jump_branch_valid;
  assign push = state == REQ && icache_ack && !flush;
  assign pop = ifq_rd_en && count != '0 && !flush;
  assign count_n = flush ? '0 : count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  assign icache_req = state != IDLE;
  assign icache_addr = pc;
  assign ifq_inst = inst_mem[rd_ptr];
  assign ifq_pc_out = pc_mem[rd_ptr];
  // pc keeps the outstanding address during DISCARD; the redirect waits in tgt
  always_comb begin
    state_n = state;
    pc_n = pc;
    tgt_n = tgt;
    if (flush) begin
      tgt_n = ifq_jump_branch_address;
      state_n = (state != IDLE && !icache_ack) ? DISCARD : REQ;
      pc_n = (state != IDLE && !icache_ack) ? pc : ifq_jump_branch_address;
    end else if (state == IDLE) begin
      state_n = count_n < FULL ? REQ : IDLE;
    end else if (icache_ack) begin
      pc_n = state == DISCARD ? tgt : pc + 32'd4;
      state_n = (state == DISCARD || count_n < FULL) ? REQ : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      tgt <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ifq_empty <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i] <= '0;
      end
    end else begin
      state <= state_n;
      pc <= pc_n;
      tgt <= tgt_n;
      count <= count_n;
      ifq_empty <= count_n == '0;
      rd_ptr <= flush ? '0 : rd_ptr + PTR_W'(pop);
      wr_ptr <= flush ? '0 : wr_ptr + PTR_W'(push);
      if (push) begin
        inst_mem[wr_ptr] <= icache_data;
        pc_mem[wr_ptr] <= pc + 32'd4;
      end
    end
  end
`ifdef IFQ_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetch_cnt <= '0;
      stat_flush_cnt <= '0;
    end else begin
      stat_fetch_cnt <= (push && stat_fetch_cnt != 16'hFFFF) ? stat_fetch_cnt + 16'd1 : stat_fetch_cnt;
      stat_flush_cnt <= (flush && stat_flush_cnt != 16'hFFFF) ? stat_flush_cnt + 16'd1 : stat_flush_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_ifq_ctrl.sv
// tb_ifq_ctrl: scoreboard bench for ifq_ctrl; stimulus queues expected fetch
// addresses and popped entries, a negedge monitor compares them.
module tb_ifq_ctrl;
  logic clk = 0, rst = 0;
  logic icache_req, icache_ack = 0, ifq_rd_en = 0, ifq_empty, jb_valid = 0;
  logic [31:0] icache_addr, icache_data = 0, ifq_inst, ifq_pc_out, jb_addr = 0;
`ifdef IFQ_STATS_EN
  logic [15:0] stat_fetch_cnt, stat_flush_cnt;
`endif
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_q[$];

  ifq_ctrl dut (
    .clk(clk), .rst(rst),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_ack(icache_ack), .icache_data(icache_data),
    .ifq_rd_en(ifq_rd_en), .ifq_inst(ifq_inst), .ifq_pc_out(ifq_pc_out),
    .ifq_empty(ifq_empty),
    .ifq_jump_branch_address(jb_addr), .ifq_jump_branch_valid(jb_valid)
`ifdef IFQ_STATS_EN
    , .stat_fetch_cnt(stat_fetch_cnt), .stat_flush_cnt(stat_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (icache_req && icache_ack) begin
        if (exp_addr.size() == 0) chk("unexpected_ack", icache_addr, 32'hFFFF_FFFF);
        else chk("fetch_addr", icache_addr, exp_addr.pop_front());
      end
      if (ifq_rd_en && !ifq_empty && !jb_valid) begin
        if (exp_q.size() == 0) chk("unexpected_pop", ifq_inst, 32'hFFFF_FFFF);
        else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("pop_inst", ifq_inst, e[63:32]);
          chk("pop_pc", ifq_pc_out, e[31:0]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_word(input logic [31:0] d, input logic [31:0] a, input bit keep);
    int n = 0;
    while (!icache_req && n < 20) begin
      cyc();
      n++;
    end
    if (!icache_req) chk("req_timeout", icache_req, 1'b1);
    icache_ack = 1;
    icache_data = d;
    exp_addr.push_back(a);
    if (keep) exp_q.push_back({d, a + 32'd4});
    cyc();
    icache_ack = 0;
  endtask

  task automatic pop();
    ifq_rd_en = 1;
    cyc();
    ifq_rd_en = 0;
  endtask

  task automatic flush(input logic [31:0] t, input bit ack_it, input logic [31:0] a, input bit rd);
    jb_valid = 1;
    jb_addr = t;
    ifq_rd_en = rd;
    exp_q.delete();
    if (ack_it) begin
      icache_ack = 1;
      icache_data = 32'hBAD0_BAD0;
      exp_addr.push_back(a);
    end
    cyc();
    jb_valid = 0;
    ifq_rd_en = 0;
    icache_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    chk("rst_req", icache_req, 1'b0);
    chk("rst_addr", icache_addr, 32'h0);
    chk("rst_inst", ifq_inst, 32'h0);
    chk("rst_pc_out", ifq_pc_out, 32'h0);
    chk("rst_empty", ifq_empty, 1'b1);
    rst = 1;
    // fill all 16 entries with back-to-back acks
    for (int i = 0; i < 16; i++) ack_word(32'h1000 + i, 32'(i * 4), 1);
    chk("full_req_drop", icache_req, 1'b0);
    chk("full_head_inst", ifq_inst, 32'h1000);
    chk("full_head_pc", ifq_pc_out, 32'h4);
    chk("full_not_empty", ifq_empty, 1'b0);
    cyc();
    cyc();
    chk("full_req_hold", icache_req, 1'b0);
    pop();
    chk("refetch_req", icache_req, 1'b1);
    chk("refetch_addr", icache_addr, 32'h40);
    for (int i = 1; i < 16; i++) pop();
    chk("drained_empty", ifq_empty, 1'b1);
    // flush while a fetch is outstanding
    flush(32'h200, 0, 32'h0, 0);
    chk("discard_req", icache_req, 1'b1);
    chk("discard_addr", icache_addr, 32'h40);
    cyc();
    cyc();
    ack_word(32'hDEAD, 32'h40, 0);
    chk("redirect_addr", icache_addr, 32'h200);
    chk("redirect_empty", ifq_empty, 1'b1);
    ack_word(32'h2000, 32'h200, 1);
    chk("redirect_push_empty", ifq_empty, 1'b0);
    chk("redirect_pc_out", ifq_pc_out, 32'h204);
    ack_word(32'h2001, 32'h204, 1);
    // flush beats a same-cycle pop; the same-cycle ack is dropped
    flush(32'h80, 1, 32'h208, 1);
    chk("flush_empty", ifq_empty, 1'b1);
    chk("flush_req", icache_req, 1'b1);
    chk("flush_addr", icache_addr, 32'h80);
    ack_word(32'h3000, 32'h80, 1);
    chk("flush_head", ifq_inst, 32'h3000);
    pop();
    for (int i = 0; i < 4; i++) ack_word(32'h4000 + i, 32'h84 + 32'(i * 4), 1);
    // steady push+pop wraps the pointers
    for (int i = 0; i < 40; i++) begin
      chk("steady_req", icache_req, 1'b1);
      icache_ack = 1;
      icache_data = 32'h5000 + i;
      ifq_rd_en = 1;
      exp_addr.push_back(32'h94 + 32'(i * 4));
      exp_q.push_back({32'h5000 + 32'(i), 32'h98 + 32'(i * 4)});
      cyc();
      chk("steady_not_empty", ifq_empty, 1'b0);
    end
    icache_ack = 0;
    ifq_rd_en = 0;
    for (int i = 0; i < 3; i++) pop();
    chk("steady_residual", ifq_empty, 1'b0);
    pop();
    chk("steady_drained", ifq_empty, 1'b1);
    pop();
    chk("underflow_empty", ifq_empty, 1'b1);
    chk("underflow_addr", icache_addr, 32'h134);
    // pc wraps past the top of the address space
    flush(32'hFFFF_FFFC, 1, 32'h134, 0);
    chk("wrap_target", icache_addr, 32'hFFFF_FFFC);
    ack_word(32'h6000, 32'hFFFF_FFFC, 1);
    chk("wrap_addr", icache_addr, 32'h0);
    pop();
    chk("final_empty", ifq_empty, 1'b1);
`ifdef IFQ_STATS_EN
    chk("stat_flush", 32'(stat_flush_cnt), 32'd3);
    chk("stat_fetch", 32'(stat_fetch_cnt), 32'd64);
`endif
    chk("addr_q_left", 32'(exp_addr.size()), 32'd0);
    chk("data_q_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
